// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD engine.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    REDUCE = 3'd2,
    SCALE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Width of the common-power-of-two counter k; never narrower than 1 bit.
  function automatic int unsigned k_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/gcd_reduce_step.sv
// One combinational REDUCE step of the binary GCD: the first matching rule
// (b==0, a even, b even, a>b swap-subtract, else b-a) defines the next pair.
module gcd_reduce_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a_nxt,
  output logic [WIDTH-1:0] o_b_nxt,
  output logic             o_done
);

  // Prioritised reduce rules; ordering guarantees subtraction never underflows.
  always_comb begin
    o_a_nxt = i_a;
    o_b_nxt = i_b;
    o_done  = (i_b == '0);
    if (o_done) begin
      o_a_nxt = i_a;
    end else if (!i_a[0]) begin
      o_a_nxt = i_a >> 1;
    end else if (!i_b[0]) begin
      o_b_nxt = i_b >> 1;
    end else if (i_a > i_b) begin
      o_a_nxt = i_b;
      o_b_nxt = i_a - i_b;
    end else begin
      o_b_nxt = i_b - i_a;
    end
  end

endmodule

// File: rtl/gcd_binary_engine.sv
// Binary (Stein) GCD engine with valid/ready handshakes on both sides.
// Optional macro GCD_CYCLE_COUNT_EN adds the out_cycles latency counter.
module gcd_binary_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
`ifdef GCD_CYCLE_COUNT_EN
  output logic [CNT_W-1:0] out_cycles,
`endif
  output logic             busy
);

  localparam int unsigned KW = k_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_gcd;
  logic             r_err;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             w_red_done;
  logic             w_accept;
  logic             w_zero_op;
  logic             w_both_even;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_zero_op   = (in_a == '0) || (in_b == '0);
  assign w_both_even = !r_a[0] && !r_b[0];

  gcd_reduce_step #(
    .WIDTH(WIDTH)
  ) u_reduce (
    .i_a     (r_a),
    .i_b     (r_b),
    .o_a_nxt (w_a_nxt),
    .o_b_nxt (w_b_nxt),
    .o_done  (w_red_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_zero_op ? DONE : SHIFT;
      SHIFT:   if (!w_both_even) w_state_nxt = REDUCE;
      REDUCE:  if (w_red_done) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, common-factor stripping, reduction and rescale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_k   <= '0;
      r_gcd <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
            r_k <= '0;
            if (w_zero_op) begin
              // With one operand zero the OR is the other operand; both zero gives 0.
              r_gcd <= in_a | in_b;
              r_err <= (in_a == '0) && (in_b == '0);
            end
          end
        end
        SHIFT: begin
          if (w_both_even) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + 1'b1;
          end
        end
        REDUCE: begin
          r_a <= w_a_nxt;
          r_b <= w_b_nxt;
        end
        SCALE: begin
          r_gcd <= r_a << r_k;
          r_err <= 1'b0;
        end
        default: begin
          r_a <= r_a;
        end
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycles;

  // Latency counter: 1 on the accept edge, +1 per working edge, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= CNT_W'(1);
    end else if ((r_state == SHIFT) || (r_state == REDUCE) || (r_state == SCALE)) begin
      if (r_cycles != '1) r_cycles <= r_cycles + 1'b1;
    end
  end

  assign out_cycles = r_cycles;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_gcd   = r_gcd;
  assign out_err   = r_err;

endmodule

// File: tb/tb_gcd_binary_engine.sv
// Directed self-checking bench for gcd_binary_engine (WIDTH=16).
module tb_gcd_binary_engine;

  localparam int unsigned W = 16;
  localparam int unsigned CW = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CW-1:0] out_cycles;
`endif

  int checks;
  int errors;

  gcd_binary_engine #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_err   (out_err),
`ifdef GCD_CYCLE_COUNT_EN
    .out_cycles(out_cycles),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Euclid by remainder: a different algorithm from the DUT's binary method.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one pair, wait for out_valid (bounded), record latency, leave result pending.
  task automatic start_wait(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      step();
      guard++;
    end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_a = $urandom;
    in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 300) begin
      step();
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout a=%0d b=%0d: out_valid=%0b after %0d cycles, required 1", a, b, out_valid, lat);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({in_ready, out_valid, out_err, busy} !== 4'b1000 || out_gcd !== '0) begin
      errors++;
      $display("FAIL reset: rdy/vld/err/busy=%b gcd=%0d, required 1000 gcd=0",
               {in_ready, out_valid, out_err, busy}, out_gcd);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    start_wait(16'd48, 16'd18, lat);
    checks++;
    if (out_gcd !== 16'd6 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_48_18: gcd=%0d err=%0b, required 6 0", out_gcd, out_err);
    end
    checks++;
    if (dut.r_k !== 4'd1) begin
      errors++;
      $display("FAIL basic_k: k=%0d, required 1", dut.r_k);
    end
    handshake();
  endtask

  task automatic test_zero();
    int lat;
    start_wait(16'd0, 16'd35, lat);
    checks++;
    if (out_gcd !== 16'd35 || out_err !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL zero_a: gcd=%0d err=%0b lat=%0d, required 35 0 1", out_gcd, out_err, lat);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (out_cycles !== 16'd1) begin
      errors++;
      $display("FAIL zero_cycles: out_cycles=%0d, required 1", out_cycles);
    end
`endif
    handshake();
    start_wait(16'd77, 16'd0, lat);
    checks++;
    if (out_gcd !== 16'd77 || out_err !== 1'b0 || lat !== 1) begin
      errors++;
      $display("FAIL zero_b: gcd=%0d err=%0b lat=%0d, required 77 0 1", out_gcd, out_err, lat);
    end
    handshake();
    start_wait(16'd0, 16'd0, lat);
    checks++;
    if (out_gcd !== 16'd0 || out_err !== 1'b1 || lat !== 1) begin
      errors++;
      $display("FAIL zero_both: gcd=%0d err=%0b lat=%0d, required 0 1 1", out_gcd, out_err, lat);
    end
    handshake();
    // An ordinary operation afterwards must clear the error flag.
    start_wait(16'd9, 16'd6, lat);
    checks++;
    if (out_gcd !== 16'd3 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: gcd=%0d err=%0b, required 3 0", out_gcd, out_err);
    end
    handshake();
  endtask

  task automatic test_boundary();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] vg [3];
    int lat;
    va = '{16'd65535, 16'd32768, 16'd65535};
    vb = '{16'd1,     16'd16384, 16'd65535};
    vg = '{16'd1,     16'd16384, 16'd65535};
    for (int i = 0; i < 3; i++) begin
      start_wait(va[i], vb[i], lat);
      checks++;
      if (out_gcd !== vg[i] || out_err !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d: gcd=%0d err=%0b, required %0d 0", i, out_gcd, out_err, vg[i]);
      end
      if (i == 1) begin
        checks++;
        if (dut.r_k !== 4'd14) begin
          errors++;
          $display("FAIL boundary_k: k=%0d, required 14", dut.r_k);
        end
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_wait(16'd100, 16'd75, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_gcd !== 16'd25 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold: %0d unstable cycles (vld=%0b gcd=%0d rdy=%0b), required 0", bad, out_valid, out_gcd, in_ready);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_gcd !== 16'd25) begin
      errors++;
      $display("FAIL release: vld=%0b rdy=%0b busy=%0b gcd=%0d, required 0 1 0 25",
               out_valid, in_ready, busy, out_gcd);
    end
    // Immediate next accept in the first IDLE cycle.
    start_wait(16'd14, 16'd21, lat);
    checks++;
    if (out_gcd !== 16'd7) begin
      errors++;
      $display("FAIL back_to_back: gcd=%0d, required 7", out_gcd);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_a = 16'd1071;
    in_b = 16'd462;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: busy=%0b vld=%0b, required 1 0", busy, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_err, busy} !== 4'b1000 || out_gcd !== '0) begin
      errors++;
      $display("FAIL mid_reset: rdy/vld/err/busy=%b gcd=%0d, required 1000 gcd=0",
               {in_ready, out_valid, out_err, busy}, out_gcd);
    end
    #2 rst_n = 1'b1;
    step();
    start_wait(16'd1071, 16'd462, lat);
    checks++;
    if (out_gcd !== 16'd21 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: gcd=%0d err=%0b, required 21 0", out_gcd, out_err);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, exp;
    int lat;
    int bad;
    int bad_cyc;
    bad = 0;
    bad_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 4 == 1) begin
        a = W'($urandom_range(0, 255)) << (i % 7);
        b = W'($urandom_range(0, 255)) << (i % 5);
      end
      if (i % 50 == 3) a = '0;
      exp = ref_gcd(a, b);
      start_wait(a, b, lat);
      if (out_gcd !== exp || out_err !== ((a == 0) && (b == 0))) begin
        bad++;
        if (bad < 5) $display("FAIL random a=%0d b=%0d: gcd=%0d, required %0d", a, b, out_gcd, exp);
      end
`ifdef GCD_CYCLE_COUNT_EN
      if (out_cycles !== CW'(lat)) bad_cyc++;
`endif
      handshake();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_total: %0d wrong results, required 0", bad);
    end
`ifdef GCD_CYCLE_COUNT_EN
    checks++;
    if (bad_cyc != 0) begin
      errors++;
      $display("FAIL cycles_total: %0d latency mismatches, required 0", bad_cyc);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_zero();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
